// File: rtl/cmp_threshold_filter_if.sv
// Sample/config bundle and filtered-decision outputs for cmp_threshold_filter.
// The master drives samples in; the slave (the filter) drives the decision out.
interface cmp_threshold_filter_if #(
    parameter int WIDTH = 8,
    parameter int OUT_W = 8,
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       op;
    logic             is_signed;
    logic [WIDTH-1:0] hyst;
    logic [CNT_W-1:0] debounce;
    logic             out_valid;
    logic [OUT_W-1:0] Out;
    logic             state;
    logic             raw;
    logic             changed;

    modport master (
        output in_valid, A, B, op, is_signed, hyst, debounce,
        input  out_valid, Out, state, raw, changed
    );

    modport slave (
        input  in_valid, A, B, op, is_signed, hyst, debounce,
        output out_valid, Out, state, raw, changed
    );
endinterface

// File: rtl/cmp_threshold_filter.sv
// Two-stage threshold comparator with hysteresis and consecutive-sample debounce.
// Stage 1 captures and extends the sample; stage 2 decides and drives the mask.
module cmp_threshold_filter #(
    parameter int WIDTH = 8,
    parameter int OUT_W = 8,
    parameter int CNT_W = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    cmp_threshold_filter_if.slave bus
);
    // Two guard bits let B +/- hyst span its full range without wrapping.
    localparam int XW = WIDTH + 2;

    localparam logic [2:0] OP_GE = 3'd0;
    localparam logic [2:0] OP_GT = 3'd1;
    localparam logic [2:0] OP_LE = 3'd2;
    localparam logic [2:0] OP_LT = 3'd3;
    localparam logic [2:0] OP_EQ = 3'd4;
    localparam logic [2:0] OP_NE = 3'd5;

    logic             r_s1_valid;
    logic [XW-1:0]    r_s1_a;
    logic [XW-1:0]    r_s1_b;
    logic [XW-1:0]    r_s1_hyst;
    logic [2:0]       r_s1_op;
    logic [CNT_W-1:0] r_s1_debounce;

    logic             r_out_valid;
    logic [OUT_W-1:0] r_out;
    logic             r_state;
    logic             r_raw;
    logic             r_changed;
    logic [CNT_W-1:0] r_cnt;

    logic [XW-1:0]    w_a_ext;
    logic [XW-1:0]    w_b_ext;
    logic [XW-1:0]    w_thr;
    logic             w_raw;
    logic             w_state_next;
    logic             w_flip;
    logic [CNT_W-1:0] w_cnt_next;

    assign w_a_ext = bus.is_signed ? {{2{bus.A[WIDTH-1]}}, bus.A} : {2'b00, bus.A};
    assign w_b_ext = bus.is_signed ? {{2{bus.B[WIDTH-1]}}, bus.B} : {2'b00, bus.B};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid    <= 1'b0;
            r_s1_a        <= '0;
            r_s1_b        <= '0;
            r_s1_hyst     <= '0;
            r_s1_op       <= '0;
            r_s1_debounce <= '0;
        end else begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_a        <= w_a_ext;
                r_s1_b        <= w_b_ext;
                r_s1_hyst     <= {2'b00, bus.hyst};
                r_s1_op       <= bus.op;
                r_s1_debounce <= bus.debounce;
            end
        end
    end

    // Hysteresis widens the band only in the direction that would release the current state.
    // Both signedness modes fit in the signed XW-bit domain, so one signed compare serves all.
    always_comb begin
        w_thr = r_s1_b;
        w_raw = 1'b0;
        case (r_s1_op)
            OP_GE, OP_GT: if (r_state) w_thr = r_s1_b - r_s1_hyst;
            OP_LE, OP_LT: if (r_state) w_thr = r_s1_b + r_s1_hyst;
            default:      w_thr = r_s1_b;
        endcase
        case (r_s1_op)
            OP_GE:   w_raw = $signed(r_s1_a) >= $signed(w_thr);
            OP_GT:   w_raw = $signed(r_s1_a) >  $signed(w_thr);
            OP_LE:   w_raw = $signed(r_s1_a) <= $signed(w_thr);
            OP_LT:   w_raw = $signed(r_s1_a) <  $signed(w_thr);
            OP_EQ:   w_raw = r_s1_a == r_s1_b;
            OP_NE:   w_raw = r_s1_a != r_s1_b;
            default: w_raw = 1'b0;
        endcase
    end

    always_comb begin
        w_flip       = 1'b0;
        w_state_next = r_state;
        w_cnt_next   = '0;
        if (w_raw != r_state) begin
            if (r_cnt == r_s1_debounce) begin
                w_flip       = 1'b1;
                w_state_next = w_raw;
            end else begin
                w_cnt_next = r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_state     <= 1'b0;
            r_raw       <= 1'b0;
            r_changed   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_out_valid <= r_s1_valid;
            r_changed   <= r_s1_valid & w_flip;
            if (r_s1_valid) begin
                r_raw   <= w_raw;
                r_state <= w_state_next;
                r_out   <= {OUT_W{w_state_next}};
                r_cnt   <= w_cnt_next;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.Out       = r_out;
    assign bus.state     = r_state;
    assign bus.raw       = r_raw;
    assign bus.changed   = r_changed;
endmodule

// File: tb/tb_cmp_threshold_filter.sv
// Directed bench for cmp_threshold_filter: a vector table walked in order (state carries
// between entries), then streaming and mid-stream reset sequences.
module tb_cmp_threshold_filter;
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic       sgn;
        logic [7:0] hyst;
        logic [3:0] deb;
        logic       e_raw;
        logic       e_state;
        logic       e_chg;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    cmp_threshold_filter_if #(.WIDTH(8), .OUT_W(8), .CNT_W(4)) bus ();

    cmp_threshold_filter #(.WIDTH(8), .OUT_W(8), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                                input logic sgn, input logic [7:0] hyst, input logic [3:0] deb,
                                input logic e_raw, input logic e_state, input logic e_chg);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.sgn = sgn; v.hyst = hyst; v.deb = deb;
        v.e_raw = e_raw; v.e_state = e_state; v.e_chg = e_chg;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input logic sgn, input logic [7:0] hyst, input logic [3:0] deb);
        bus.in_valid = v; bus.A = a; bus.B = b; bus.op = op;
        bus.is_signed = sgn; bus.hyst = hyst; bus.debounce = deb;
    endtask

    // One sample: checks exact 2-cycle latency, the result, and that outputs hold afterwards.
    task automatic apply(input vec_t v, input int idx);
        drive(1'b1, v.a, v.b, v.op, v.sgn, v.hyst, v.deb);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk($sformatf("v%0d_early_valid", idx), int'(bus.out_valid), 0);
        @(posedge clk); #1;
        chk($sformatf("v%0d_valid", idx), int'(bus.out_valid), 1);
        chk($sformatf("v%0d_raw", idx), int'(bus.raw), int'(v.e_raw));
        chk($sformatf("v%0d_state", idx), int'(bus.state), int'(v.e_state));
        chk($sformatf("v%0d_changed", idx), int'(bus.changed), int'(v.e_chg));
        chk($sformatf("v%0d_out", idx), int'(bus.Out), v.e_state ? 255 : 0);
        @(posedge clk); #1;
        chk($sformatf("v%0d_hold_valid", idx), int'(bus.out_valid), 0);
        chk($sformatf("v%0d_hold_changed", idx), int'(bus.changed), 0);
        chk($sformatf("v%0d_hold_state", idx), int'(bus.state), int'(v.e_state));
        $display("vec %0d: A=%0d B=%0d op=%0d s=%0d h=%0d d=%0d -> raw=%0d state=%0d chg=%0d",
                 idx, v.a, v.b, v.op, v.sgn, v.hyst, v.deb, bus.raw, bus.state, v.e_chg);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[26];
        logic exp_st[8];
        int   nvalid;

        vecs[0]  = mk(8'd200, 8'd100, 3'd0, 1'b0, 8'd0,   4'd0, 1, 1, 1);
        vecs[1]  = mk(8'd50,  8'd100, 3'd0, 1'b0, 8'd0,   4'd0, 0, 0, 1);
        vecs[2]  = mk(8'h80,  8'h01,  3'd0, 1'b0, 8'd0,   4'd0, 1, 1, 1);
        vecs[3]  = mk(8'h80,  8'h01,  3'd0, 1'b1, 8'd0,   4'd0, 0, 0, 1);
        vecs[4]  = mk(8'd200, 8'd100, 3'd0, 1'b0, 8'd10,  4'd0, 1, 1, 1);
        vecs[5]  = mk(8'd95,  8'd100, 3'd0, 1'b0, 8'd10,  4'd0, 1, 1, 0);
        vecs[6]  = mk(8'd89,  8'd100, 3'd0, 1'b0, 8'd10,  4'd0, 0, 0, 1);
        vecs[7]  = mk(8'd99,  8'd100, 3'd0, 1'b0, 8'd10,  4'd0, 0, 0, 0);
        vecs[8]  = mk(8'd100, 8'd100, 3'd0, 1'b0, 8'd10,  4'd0, 1, 1, 1);
        vecs[9]  = mk(8'd5,   8'd10,  3'd0, 1'b0, 8'd0,   4'd0, 0, 0, 1);
        vecs[10] = mk(8'd20,  8'd10,  3'd0, 1'b0, 8'd0,   4'd2, 1, 0, 0);
        vecs[11] = mk(8'd20,  8'd10,  3'd0, 1'b0, 8'd0,   4'd2, 1, 0, 0);
        vecs[12] = mk(8'd5,   8'd10,  3'd0, 1'b0, 8'd0,   4'd2, 0, 0, 0);
        vecs[13] = mk(8'd20,  8'd10,  3'd0, 1'b0, 8'd0,   4'd2, 1, 0, 0);
        vecs[14] = mk(8'd20,  8'd10,  3'd0, 1'b0, 8'd0,   4'd2, 1, 0, 0);
        vecs[15] = mk(8'd20,  8'd10,  3'd0, 1'b0, 8'd0,   4'd2, 1, 1, 1);
        vecs[16] = mk(8'h00,  8'hFF,  3'd2, 1'b0, 8'hFF,  4'd0, 1, 1, 0);
        vecs[17] = mk(8'hFF,  8'hFF,  3'd3, 1'b0, 8'hFF,  4'd0, 1, 1, 0);
        vecs[18] = mk(8'd7,   8'd7,   3'd4, 1'b0, 8'd0,   4'd0, 1, 1, 0);
        vecs[19] = mk(8'd7,   8'd7,   3'd5, 1'b0, 8'd0,   4'd0, 0, 0, 1);
        vecs[20] = mk(8'd7,   8'd7,   3'd6, 1'b0, 8'd0,   4'd0, 0, 0, 0);
        vecs[21] = mk(8'd100, 8'd100, 3'd1, 1'b0, 8'd0,   4'd0, 0, 0, 0);
        vecs[22] = mk(8'd101, 8'd100, 3'd1, 1'b0, 8'd0,   4'd0, 1, 1, 1);
        vecs[23] = mk(8'd5,   8'd10,  3'd3, 1'b0, 8'd3,   4'd0, 1, 1, 0);
        vecs[24] = mk(8'd14,  8'd10,  3'd2, 1'b0, 8'd3,   4'd0, 0, 0, 1);
        vecs[25] = mk(8'd11,  8'd10,  3'd2, 1'b0, 8'd3,   4'd0, 0, 0, 0);

        drive(1'b0, 8'd0, 8'd0, 3'd0, 1'b0, 8'd0, 4'd0);
        #12;
        chk("rst_valid",   int'(bus.out_valid), 0);
        chk("rst_out",     int'(bus.Out), 0);
        chk("rst_state",   int'(bus.state), 0);
        chk("rst_raw",     int'(bus.raw), 0);
        chk("rst_changed", int'(bus.changed), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_valid", int'(bus.out_valid), 0);

        for (int i = 0; i < 26; i++) apply(vecs[i], i);

        // Streaming from state=0: A alternates 20/5 against GE 10, so every result flips.
        for (int i = 0; i < 8; i++) exp_st[i] = (i % 2 == 0);
        nvalid = 0;
        for (int c = 0; c < 10; c++) begin
            if (c < 8) drive(1'b1, (c % 2 == 0) ? 8'd20 : 8'd5, 8'd10, 3'd0, 1'b0, 8'd0, 4'd0);
            else       bus.in_valid = 1'b0;
            @(posedge clk); #1;
            if (bus.out_valid) nvalid++;
            if (c == 0) chk("stream_first_valid", int'(bus.out_valid), 0);
            else if (c <= 8) begin
                chk($sformatf("stream%0d_valid", c - 1), int'(bus.out_valid), 1);
                chk($sformatf("stream%0d_state", c - 1), int'(bus.state), int'(exp_st[c-1]));
                chk($sformatf("stream%0d_changed", c - 1), int'(bus.changed), 1);
                $display("stream %0d: state=%0d changed=%0d", c - 1, bus.state, bus.changed);
            end
        end
        chk("stream_count", nvalid, 8);

        // Mid-stream reset with state=1: outputs clear at once, in-flight samples vanish.
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 8'd20, 8'd10, 3'd0, 1'b0, 8'd0, 4'd0);
            @(posedge clk); #1;
        end
        chk("prerst_state", int'(bus.state), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_valid", int'(bus.out_valid), 0);
        chk("midrst_out",   int'(bus.Out), 0);
        chk("midrst_state", int'(bus.state), 0);
        chk("midrst_changed", int'(bus.changed), 0);
        bus.in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        nvalid = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) nvalid++;
        end
        chk("post_midrst_stale_valid", nvalid, 0);
        chk("post_midrst_state", int'(bus.state), 0);
        $display("mid-stream reset: state=%0d Out=%0d stale_valid=%0d", bus.state, bus.Out, nvalid);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
